// File: rtl/led_trace_capture_pkg.sv
// Shared types and defaults for the LED/probe trace capture block.
// Holds the capture FSM state encoding and the FIFO entry-width helper.
package led_trace_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefChannels = 1;
  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefDepth    = 16;
  localparam int unsigned DefTsWidth  = 16;

  // A FIFO entry is {timestamp, sample}.
  function automatic int unsigned entry_width(input int unsigned ts_w,
                                              input int unsigned sample_w);
    return ts_w + sample_w;
  endfunction

endpackage

// File: rtl/led_trace_capture_if.sv
// Valid/ready readout stream carrying one timestamped trace entry per beat.
interface led_trace_capture_if
  import led_trace_pkg::*;
#(
  parameter int unsigned TS_WIDTH     = DefTsWidth,
  parameter int unsigned SAMPLE_WIDTH = DefChannels * DefWidth
) ();

  logic                    out_valid;
  logic                    out_ready;
  logic [TS_WIDTH-1:0]     out_ts;
  logic [SAMPLE_WIDTH-1:0] out_sample;

  modport master (
    output out_valid,
    output out_ts,
    output out_sample,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ts,
    input  out_sample,
    output out_ready
  );

endinterface

// File: rtl/led_trace_capture_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is read straight from storage.
// A push while full is only accepted when a pop frees the slot on the same edge.
module trace_fifo #(
  parameter int unsigned WIDTH_D = 24,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH_D-1:0]       wdata,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH_D-1:0]       rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthL = (AW + 1)'(DEPTH);

  logic [WIDTH_D-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DepthL);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem_q[rd_ptr_q];
    level   = count_q;
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/led_trace_capture.sv
// Timestamped capture of the LED/probe bus into a FIFO, drained over a valid/ready stream.
// Records every cycle or only on change; a stop request drains the buffer and raises done.
module led_trace_capture
  import led_trace_pkg::*;
#(
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned TS_WIDTH = DefTsWidth
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        start,
  input  logic                        stop,
  input  logic [CHANNELS*WIDTH-1:0]   probe_in,
  led_trace_capture_if.master         out_if,
  output logic                        capturing,
  output logic                        done,
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int unsigned SW = CHANNELS * WIDTH;
  localparam int unsigned EW = entry_width(TS_WIDTH, SW);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_e              state_q;
  logic                mode_q, first_q, overflow_q, capturing_q, done_q;
  logic [TS_WIDTH-1:0] ts_q;
  logic [SW-1:0]       prev_q;

  logic          launch, push, pop, full, empty, drain_empty;
  logic [EW-1:0] wdata, rdata;
  logic [LW-1:0] fifo_level;

  always_comb begin
    launch = ((state_q == StIdle) || (state_q == StDone)) && start && !stop;
    // Change detection compares against the previous cycle's sample, recorded or not.
    push   = (state_q == StCapture) && (!mode_q || first_q || (probe_in != prev_q));
    pop    = !empty && out_if.out_ready;
    wdata  = {ts_q, probe_in};
    drain_empty = (fifo_level == '0) || ((fifo_level == LW'(1)) && pop);
  end

  trace_fifo #(
    .WIDTH_D (EW),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (launch),
    .push  (push),
    .wdata (wdata),
    .full  (full),
    .pop   (pop),
    .rdata (rdata),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      first_q     <= 1'b0;
      overflow_q  <= 1'b0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
      ts_q        <= '0;
      prev_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (launch) begin
            state_q     <= StCapture;
            mode_q      <= mode;
            first_q     <= 1'b1;
            overflow_q  <= 1'b0;
            capturing_q <= 1'b1;
            done_q      <= 1'b0;
            ts_q        <= '0;
          end
        end
        StCapture: begin
          ts_q    <= ts_q + 1'b1;
          prev_q  <= probe_in;
          first_q <= 1'b0;
          if (push && full && !pop) overflow_q <= 1'b1;
          if (stop) begin
            state_q     <= StDrain;
            capturing_q <= 1'b0;
          end
        end
        StDrain: begin
          if (drain_empty) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_if.out_valid  = !empty;
  assign out_if.out_ts     = rdata[EW-1 -: TS_WIDTH];
  assign out_if.out_sample = rdata[SW-1:0];
  assign capturing         = capturing_q;
  assign done              = done_q;
  assign overflow          = overflow_q;
  assign level             = fifo_level;

endmodule

// File: tb/tb_led_trace_capture.sv
// Directed bench for led_trace_capture: a 16-bit-timestamp instance and a 4-bit one share stimulus.
module tb_led_trace_capture;
  import led_trace_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] probe_in = 8'h00;

  logic       capturing_a, done_a, overflow_a;
  logic       capturing_b, done_b, overflow_b;
  logic [4:0] level_a, level_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_trace_capture_if #(.TS_WIDTH(16), .SAMPLE_WIDTH(8)) if_a ();
  led_trace_capture_if #(.TS_WIDTH(4),  .SAMPLE_WIDTH(8)) if_b ();

  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  led_trace_capture #(
    .CHANNELS (1),
    .WIDTH    (8),
    .DEPTH    (16),
    .TS_WIDTH (16)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .probe_in  (probe_in),
    .out_if    (if_a),
    .capturing (capturing_a),
    .done      (done_a),
    .overflow  (overflow_a),
    .level     (level_a)
  );

  led_trace_capture #(
    .CHANNELS (1),
    .WIDTH    (8),
    .DEPTH    (16),
    .TS_WIDTH (4)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .probe_in  (probe_in),
    .out_if    (if_b),
    .capturing (capturing_b),
    .done      (done_b),
    .overflow  (overflow_b),
    .level     (level_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_valid", 32'(if_a.out_valid), 0);
    check("rst_level", 32'(level_a), 0);
    check("rst_capturing", 32'(capturing_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_overflow", 32'(overflow_a), 0);
    reset = 1'b1;
    step();
    check("idle_capturing", 32'(capturing_a), 0);

    // Record-every-cycle, consumer always ready
    mode  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("m0_capturing", 32'(capturing_a), 1);
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      probe_in = 8'(i);
      stop     = (i == 5);
      step();
      check("m0_valid", 32'(if_a.out_valid), 1);
      check("m0_ts", 32'(if_a.out_ts), 32'(i));
      check("m0_sample", 32'(if_a.out_sample), 32'(i));
      check("m0_level", 32'(level_a), 1);
    end
    stop = 1'b0;
    step();
    check("m0_done", 32'(done_a), 1);
    check("m0_valid_end", 32'(if_a.out_valid), 0);
    check("m0_level_end", 32'(level_a), 0);
    check("m0_overflow", 32'(overflow_a), 0);
    check("m0_capturing_end", 32'(capturing_a), 0);

    // Record-on-change
    ready = 1'b0;
    mode  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      probe_in = (i < 4) ? 8'hA5 : 8'h5A;
      stop     = (i == 6);
      step();
    end
    stop = 1'b0;
    check("m1_level", 32'(level_a), 2);
    check("m1_ts0", 32'(if_a.out_ts), 0);
    check("m1_s0", 32'(if_a.out_sample), 32'h A5);
    ready = 1'b1;
    step();
    check("m1_ts1", 32'(if_a.out_ts), 4);
    check("m1_s1", 32'(if_a.out_sample), 32'h5A);
    step();
    check("m1_done", 32'(done_a), 1);
    check("m1_level_end", 32'(level_a), 0);

    // Overflow: 20 samples into 16 entries with consumer stalled
    ready = 1'b0;
    mode  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ov_done_clr", 32'(done_a), 0);
    check("ov_capturing", 32'(capturing_a), 1);
    for (int i = 0; i < 20; i++) begin
      probe_in = 8'(8'h10 + i);
      stop     = (i == 19);
      step();
    end
    stop = 1'b0;
    check("ov_level", 32'(level_a), 16);
    check("ov_overflow", 32'(overflow_a), 1);
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("ov_ts", 32'(if_a.out_ts), 32'(k));
      check("ov_sample", 32'(if_a.out_sample), 32'(8'h10 + k));
      step();
    end
    check("ov_done", 32'(done_a), 1);
    check("ov_level_end", 32'(level_a), 0);
    check("ov_sticky", 32'(overflow_a), 1);

    // Full FIFO with simultaneous pop: pushes accepted, nothing lost
    ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("fp_ov_clr", 32'(overflow_a), 0);
    for (int i = 0; i < 16; i++) begin
      probe_in = 8'(8'h40 + i);
      step();
    end
    check("fp_level_full", 32'(level_a), 16);
    check("fp_ov_full", 32'(overflow_a), 0);
    ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("fp_head_ts", 32'(if_a.out_ts), 32'(j));
      probe_in = 8'(8'h50 + j);
      stop     = (j == 3);
      step();
      check("fp_level_hold", 32'(level_a), 16);
    end
    stop = 1'b0;
    check("fp_ov_hold", 32'(overflow_a), 0);
    for (int k = 4; k < 20; k++) begin
      check("fp_ts", 32'(if_a.out_ts), 32'(k));
      check("fp_sample", 32'(if_a.out_sample), 32'(8'h40 + k));
      step();
    end
    check("fp_done", 32'(done_a), 1);
    check("fp_ov_end", 32'(overflow_a), 0);

    // Reset mid-capture, then start+stop together in IDLE
    ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      probe_in = 8'(8'h60 + i);
      step();
    end
    check("rc_level", 32'(level_a), 5);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rc_valid", 32'(if_a.out_valid), 0);
    check("rc_level0", 32'(level_a), 0);
    check("rc_capturing", 32'(capturing_a), 0);
    check("rc_level_b", 32'(level_b), 0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_capturing", 32'(capturing_a), 0);
    check("ss_level", 32'(level_a), 0);
    step();
    check("ss_capturing2", 32'(capturing_a), 0);
    check("ss_done", 32'(done_a), 0);

    // Timestamp wrap on the 4-bit instance
    ready = 1'b1;
    mode  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      probe_in = 8'(8'h80 + i);
      stop     = (i == 17);
      step();
      check("wr_ts_b", 32'(if_b.out_ts), 32'(i % 16));
      check("wr_sample_b", 32'(if_b.out_sample), 32'(8'h80 + i));
      check("wr_ts_a", 32'(if_a.out_ts), 32'(i));
    end
    stop = 1'b0;
    step();
    check("wr_done_b", 32'(done_b), 1);
    check("wr_done_a", 32'(done_a), 1);
    check("wr_ov_b", 32'(overflow_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_trace_capture.md
# led_trace_capture

Parametrised capture engine for the board's LED/probe outputs, sitting between the core's LED bus and the debug readout path. It samples CHANNELS×WIDTH probe bits each cycle, timestamps them, and buffers either every sample or only changed samples in an on-chip FIFO for readout over a valid/ready stream. A stop request ends capture, drains the buffer and raises `done`, replacing the print-every-cycle-until-stop checking with a synthesizable, bounded trace.

## Interface
- CHANNELS, 1: number of probe channels
- WIDTH, 8: bits per channel (8 = one LED bank)
- DEPTH, 16: FIFO entries, power of two, ≥2
- TS_WIDTH, 16: timestamp width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset reset, synchronous, active-low
- mode  in  1  0 = record every cycle, 1 = record on change only; sampled on `start`
- start  in  1  single-cycle pulse, begin capture
- stop  in  1  single-cycle pulse, end capture
- probe_in  in  CHANNELS*WIDTH  sampled bus, channel 0 in LSBs
- out_valid  out  1  FIFO head available
- out_ready  in  1  consumer accepts head
- out_ts  out  TS_WIDTH  timestamp of head entry
- out_sample  out  CHANNELS*WIDTH  sample of head entry
- capturing  out  1  high in CAPTURE
- done  out  1  high in DONE
- overflow  out  1  sticky, a sample was dropped
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE. Reset → IDLE; all outputs 0, FIFO empty, ts 0.
- IDLE: `start` → CAPTURE; latch `mode`, clear ts, FIFO, overflow. `start`+`stop` same cycle: stays IDLE.
- CAPTURE: each cycle forms entry {ts, probe_in}; ts increments by 1, wraps modulo 2^TS_WIDTH. `stop` → DRAIN; the sample in the `stop` cycle is still recorded. `start` ignored.
- mode 1: entry pushed only if probe_in differs from last sampled value (compared against previous cycle's sample, recorded or not); first CAPTURE cycle always pushed. mode 0: pushed every cycle.
- Push when full and no pop same cycle: entry dropped, overflow set, stays set until next `start`. Full with pop same cycle: push accepted.
- DRAIN: no pushes; → DONE on the cycle level reaches 0.
- DONE: `done`=1, holds until `start` (→ CAPTURE, clears as in IDLE) or reset.
- Pop: out_valid && out_ready. Readout allowed in CAPTURE, DRAIN, DONE (DONE is always empty).
- Reset mid-capture: FIFO contents lost, IDLE next cycle.

## Timing
- Sample presented at edge N is visible on out_valid/out_ts/out_sample at edge N+1 earliest (registered FIFO, first-word-fall-through head).
- out_ts/out_sample stable while out_valid && !out_ready.
- level updates same edge as push/pop; simultaneous push+pop leaves level unchanged.
- capturing rises 1 cycle after `start`; done rises the cycle after last pop in DRAIN (or 1 cycle after `stop` if empty).
- Throughput: 1 push and 1 pop per cycle.

## Structure
- `led_trace_pkg`: state enum (IDLE/CAPTURE/DRAIN/DONE), default parameter constants, entry-width helper function.
- Sub-module `trace_fifo`: synchronous FWFT FIFO, params WIDTH_D, DEPTH; push/full, pop/empty, level. Top holds FSM, ts counter, change detect, overflow.

## Test plan
- mode 0, probe_in counts 0x00..0x05, `stop` after 6 cycles, out_ready=1 → 6 entries ts 0..5, samples 0x00..0x05, done after drain, overflow 0.
- mode 1, probe_in 0xA5 ×4 then 0x5A ×3, stop → exactly 2 entries: (ts 0, 0xA5), (ts 4, 0x5A).
- DEPTH=16, mode 0, out_ready=0 for 20 cycles → level 16, overflow 1; then ready=1 → first 16 samples (ts 0..15) read in order.
- Full FIFO, out_ready=1 same cycles as pushes → level stays 16, no overflow, no lost entries.
- Reset asserted low mid-CAPTURE with level 5 → next cycle IDLE, out_valid 0, level 0, capturing 0; `start` with `stop` same cycle in IDLE → stays IDLE.
- TS_WIDTH=4, mode 0, 18 cycles with ready=1 → ts sequence 0..15, 0, 1.
